gaussian_frame_ctrl: RTL and testbench

- Frame sequencer for the 5x5 separable Gaussian filter.
- Drives the filter clock-enable, zero-pad and clear strobes, and gates the input pixel stream with a ready/valid handshake.
- Flushes the 2-row + 2-pixel pipeline at end of frame.
- Tags each filter output with coordinates, a border flag and valid, for the DoG/extrema stage downstream.

---
 rtl/gaussian_frame_ctrl.sv | 120 ++++++++++++
 tb/tb_gaussian_frame_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gaussian_frame_ctrl.sv
// Frame sequencer for the 5x5 separable Gaussian filter.
// Clears the filter, gates the pixel stream, flushes the 2-row + 2-pixel
// pipeline with zero padding and tags each centred result with its
// coordinates and a border flag for the DoG/extrema stage.
module gaussian_frame_ctrl #(
    parameter int IMG_W = 400,
    parameter int IMG_H = 300,
    parameter int HALF  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic                     filt_ce,
    output logic                     filt_clr,
    output logic                     filt_zero,
    output logic                     out_valid,
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic [$clog2(IMG_H)-1:0] out_y,
    output logic                     out_border,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int LAT   = HALF * IMG_W + HALF;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int TOTAL = NPIX + LAT;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] LAT_C      = CW'(LAT);
    localparam logic [CW-1:0] LAST_PIX_C = CW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_BT_C  = CW'(TOTAL - 1);
    localparam logic [XW-1:0] X_LO       = XW'(HALF);
    localparam logic [XW-1:0] X_HI       = XW'(IMG_W - HALF);
    localparam logic [XW-1:0] X_MAX      = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LO       = YW'(HALF);
    localparam logic [YW-1:0] Y_HI       = YW'(IMG_H - HALF);
    localparam logic [YW-1:0] Y_MAX      = YW'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   beat_cnt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and strobe decode; every output is derived from state and
    // live handshakes so a stall never needs to be undone
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        filt_ce   = 1'b0;
        filt_clr  = 1'b0;
        filt_zero = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                filt_clr  = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                in_ready = out_ready;
                filt_ce  = in_valid & out_ready;
                if (filt_ce && beat_cnt == LAST_PIX_C) state_nxt = FLUSH;
            end
            FLUSH: begin
                filt_zero = 1'b1;
                filt_ce   = out_ready;
                if (filt_ce && beat_cnt == LAST_BT_C) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result tagging: first LAT beats only prime the line buffers
    always_comb begin
        out_valid  = filt_ce & (beat_cnt >= LAT_C);
        frame_done = out_valid & (beat_cnt == LAST_BT_C);
        // Gated by valid so the flag stays quiet between results and in reset
        out_border = out_valid & ((out_x < X_LO) | (out_x >= X_HI) |
                                  (out_y < Y_LO) | (out_y >= Y_HI));
    end

    // Beat counter and raster coordinates; they only move on a filter beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            out_x    <= '0;
            out_y    <= '0;
        end else if (state == CLEAR) begin
            beat_cnt <= '0;
            out_x    <= '0;
            out_y    <= '0;
        end else if (filt_ce) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (out_valid) begin
                if (out_x == X_MAX) begin
                    out_x <= '0;
                    out_y <= (out_y == Y_MAX) ? '0 : out_y + 1'b1;
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
// Randomised bench for gaussian_frame_ctrl on an 8x6 frame. The reference
// model tracks only "frame active" and the number of filter beats, and
// derives every expected strobe and coordinate arithmetically from those.
module tb_gaussian_frame_ctrl;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int HALF  = 2;
    localparam int LAT   = HALF * W + HALF;
    localparam int NPIX  = W * H;
    localparam int TOTAL = NPIX + LAT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, filt_ce, filt_clr, filt_zero, out_valid;
    logic [2:0] out_x, out_y;
    logic       out_border, busy, frame_done;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit m_active = 0, m_clr = 0;
    int m_beats  = 0;

    // per-frame observations
    int cyc = 0, o_ce, o_val, o_bord, o_first_beat, o_done_cyc, o_busy_after;

    gaussian_frame_ctrl #(.IMG_W(W), .IMG_H(H), .HALF(HALF)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .out_ready(out_ready), .filt_ce(filt_ce),
        .filt_clr(filt_clr), .filt_zero(filt_zero), .out_valid(out_valid),
        .out_x(out_x), .out_y(out_y), .out_border(out_border), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_ce"}, filt_ce, 0);
        chk({tag, "_clr"}, filt_clr, 0);
        chk({tag, "_zero"}, filt_zero, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_x"}, out_x, 0);
        chk({tag, "_y"}, out_y, 0);
        chk({tag, "_border"}, out_border, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
    endtask

    // One clock: inputs are already driven; check at negedge, advance model
    task automatic step();
        bit strm, flsh, fin, e_ce, e_val, e_bord;
        int idx, ex, ey;
        @(negedge clk);
        strm  = m_active && !m_clr && m_beats < NPIX;
        flsh  = m_active && !m_clr && m_beats >= NPIX && m_beats < TOTAL;
        fin   = m_active && !m_clr && m_beats == TOTAL;
        e_ce  = strm ? (in_valid && out_ready) : (flsh ? out_ready : 1'b0);
        e_val = e_ce && m_beats >= LAT;
        chk("busy", busy, m_active);
        chk("clr", filt_clr, m_active && m_clr);
        chk("in_ready", in_ready, strm && out_ready);
        chk("zero", filt_zero, flsh);
        chk("ce", filt_ce, e_ce);
        chk("valid", out_valid, e_val);
        chk("frame_done", frame_done, e_ce && m_beats == TOTAL - 1);
        if (e_val) begin
            idx    = m_beats - LAT;
            ex     = idx % W;
            ey     = idx / W;
            e_bord = ex < HALF || ex >= W - HALF || ey < HALF || ey >= H - HALF;
            chk("x", out_x, ex);
            chk("y", out_y, ey);
            chk("border", out_border, e_bord);
        end
        // observation statistics from the DUT pins
        if (filt_ce) o_ce++;
        if (out_valid) begin
            o_val++;
            if (o_first_beat < 0) o_first_beat = o_ce;
            if (out_border) o_bord++;
        end
        if (o_done_cyc >= 0 && cyc > o_done_cyc && busy) o_busy_after++;
        if (frame_done) o_done_cyc = cyc;
        cyc++;
        // model advance
        if (!m_active) begin
            if (start) begin m_active = 1; m_clr = 1; m_beats = 0; end
        end else if (m_clr)  m_clr = 0;
        else if (fin)        m_active = 0;
        else if (e_ce)       m_beats++;
        @(posedge clk); #1;
    endtask

    // mode 0: steady, 1: valid toggling, 2: planned stalls, 3: random + start
    // re-pulses, 4: abort by reset at beat 30
    task automatic run_frame(input int mode, input string name);
        int budget = 3000;
        int stall  = 0;
        bit s20 = 0, s55 = 0, aborted = 0;
        o_ce = 0; o_val = 0; o_bord = 0; o_first_beat = -1;
        o_done_cyc = -1; o_busy_after = 0;
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        while (m_active && budget > 0) begin
            budget--;
            case (mode)
                1: in_valid = ~in_valid;
                2: begin
                    if (m_beats == 20 && !s20) begin s20 = 1; stall = 5; end
                    if (m_beats == 55 && !s55) begin s55 = 1; stall = 5; end
                    out_ready = (stall == 0);
                    if (stall > 0) stall--;
                end
                3: begin
                    in_valid  = ($urandom_range(3, 0) != 0);
                    out_ready = ($urandom_range(3, 0) != 0);
                    start     = ($urandom_range(7, 0) == 0);
                end
                4: if (m_beats == 30) begin
                    #2 rst = 1'b0;
                    #1 chk_all_zero("abort");
                    m_active = 0; m_clr = 0; m_beats = 0;
                    @(negedge clk); rst = 1'b1;
                    @(posedge clk); #1;
                    aborted = 1;
                    break;
                end
                default: ;
            endcase
            step();
        end
        start = 1'b0;
        if (budget == 0) chk({name, "_timeout"}, 1, 0);
        if (!aborted) begin
            chk({name, "_ce_total"}, o_ce, TOTAL);
            chk({name, "_valid_total"}, o_val, NPIX);
            chk({name, "_border_total"}, o_bord, 40);
            chk({name, "_first_valid_beat"}, o_first_beat, LAT + 1);
            chk({name, "_busy_after_done"}, o_busy_after, 1);
        end
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        // a few idle cycles with noise on inputs that must be ignored
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            step();
        end
        run_frame(0, "steady");
        run_frame(1, "toggle");
        run_frame(2, "stall");
        run_frame(3, "random");
        run_frame(4, "abort");
        run_frame(0, "after_abort");
        // back-to-back: each run_frame starts the cycle after DONE
        run_frame(0, "b2b_a");
        run_frame(3, "b2b_b");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
